fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 Port: start_i  in  1  enable; fetching begins on the first edge it is sampled high.
REQ-005 Port: stall_i  in  1  downstream IF/ID hold; output slot is not consumed this cycle.
REQ-006 Port: redirect_i  in  1  branch/flush request; overrides stall_i.
REQ-007 Port: redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 Port: imem_req_o  out  1  instruction-memory request.
REQ-009 Port: imem_addr_o  out  32  request address, word aligned.
REQ-010 Port: imem_ack_i  in  1  response; sampled only while imem_req_o=1; data valid same cycle.
REQ-011 Port: imem_rdata_i  in  32  fetched instruction.
REQ-012 Port: pc_o  out  32  address of the instruction in instr_o.
REQ-013 Port: instr_o  out  32  instruction to IF/ID; 0 when valid_o=0.
REQ-014 Port: valid_o  out  1  output slot holds a real instruction.

Function
REQ-015 FSM states SHALL be IDLE, REQ, HOLD, DRAIN; internal fetch PC register pc_q; one skid register (pc, instr).
REQ-016 IDLE: imem_req_o=0; start_i=1 -> REQ; start_i is ignored in every other state.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc_q; req and addr stay stable until imem_ack_i, even if stall_i rises.
REQ-018 REQ, ack, slot free (valid_o=0 or stall_i=0): pc_o<=pc_q, instr_o<=imem_rdata_i, valid_o<=1, pc_q<=pc_q+4; stay REQ (throughput 1 instr/cycle with zero-wait memory).
REQ-019 REQ, ack, slot occupied (valid_o=1 and stall_i=1): data to skid, pc_q<=pc_q+4 -> HOLD.
REQ-020 REQ, no ack, stall_i=0: valid_o<=0, instr_o<=0 (bubble).
REQ-021 Any state, stall_i=1 and no redirect: pc_o/instr_o/valid_o SHALL hold.
REQ-022 HOLD: imem_req_o=0; on stall_i=0 skid moves to output, valid_o<=1 -> REQ.
REQ-023 redirect_i=1: pc_q<={redirect_pc_i[31:2],2'b00}, valid_o<=0, instr_o<=0, pc_o<=0, skid discarded, regardless of stall_i.
REQ-024 Redirect in REQ without ack -> DRAIN; DRAIN keeps imem_req_o=1 at old address until ack, discards data -> REQ.
REQ-025 Redirect in REQ with ack same cycle: data discarded -> REQ at new pc (no DRAIN).
REQ-026 Redirect in HOLD -> REQ; in IDLE -> pc_q updated, stays IDLE; in DRAIN -> pc_q updated, stays DRAIN.
REQ-027 pc_q+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 Latency: instruction appears on outputs the edge after its ack when the slot is free.

Reset
REQ-029 rst_i=1 at an edge: state IDLE, pc_q=RESET_PC, pc_o=0, instr_o=0, valid_o=0, skid cleared; priority over redirect, stall, ack.
REQ-030 Reset mid-request drops the transaction; imem_req_o=0 the cycle after reset is sampled.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, NOP_INSTR (32'h0) and the default RESET_PC.
REQ-032 Single module, no sub-modules; next-PC adder and FSM inline.

Verification
REQ-033 Reset, start_i=1, zero-wait memory -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; valid_o=1 from the second cycle, pc_o trailing by one.
REQ-034 2-wait memory at 0x10 with stall_i toggling mid-request -> addr held at 0x10 for 3 cycles; one instruction delivered, none duplicated.
REQ-035 valid_o=1 (pc_o=0x8), stall_i=1, ack for 0xC -> HOLD; stall_i=0 -> pc_o=0xC; next request 0x10.
REQ-036 redirect_i=1, redirect_pc_i=0x103 during 2-wait fetch of 0x20 -> DRAIN, 0x20 data discarded, next addr 0x100, valid_o=0 until 0x100 returns.
REQ-037 redirect_i and stall_i both 1 with valid_o=1 -> valid_o=0, instr_o=0 next cycle.
REQ-038 redirect_pc_i=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0; rst_i mid-run -> all outputs 0, first post-start fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid
// buffer behind a stallable IF/ID output slot, and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  instr_o,
  output logic         valid_o,
  output fetch_state_e state_o
);

  // imem handshake: a request is raised with its address and both stay
  // stable until imem_ack_i is seen high in a cycle where imem_req_o=1; the
  // data is taken in that same cycle. ack while req=0 is ignored.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic         slot_free;
  logic [31:0]  pc_plus4;

  assign slot_free = !out_valid_q || !stall_i;
  assign pc_plus4  = pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_valid_q  <= out_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_valid_d  = out_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_i) begin
      pc_d         = align_pc(redirect_pc_i);
      out_pc_d     = '0;
      out_instr_d  = NOP_INSTR;
      out_valid_d  = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      unique case (state_q)
        REQ: begin
          // An un-acked request must still complete at its old address.
          drain_addr_d = pc_q;
          state_d      = imem_ack_i ? REQ : DRAIN;
        end
        HOLD:    state_d = REQ;
        // Leave DRAIN only once the outstanding old request has completed.
        DRAIN:   state_d = imem_ack_i ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) state_d = REQ;
        end
        REQ: begin
          if (imem_ack_i) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              out_pc_d    = pc_q;
              out_instr_d = imem_rdata_i;
              out_valid_d = 1'b1;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata_i;
              state_d      = HOLD;
            end
          end else if (!stall_i) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            out_pc_d    = skid_pc_q;
            out_instr_d = skid_instr_q;
            out_valid_d = 1'b1;
            state_d     = REQ;
          end
        end
        DRAIN: begin
          if (imem_ack_i) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr_o = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign pc_o        = out_pc_q;
  assign instr_o     = out_instr_q;
  assign valid_o     = out_valid_q;
  assign state_o     = state_q;

endmodule
